// File: rtl/pulse_cmd_sched.sv
// Command decoder for pulse_gen: assembles 5-byte UART frames into staged timing registers,
// commits them to the live outputs on a period boundary, and returns a one-byte acknowledge.
module pulse_cmd_sched #(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter logic [31:0] DEF_DELAY   = 32'd100,
    parameter logic [31:0] DEF_PERIOD  = 32'd50000,
    parameter logic [31:0] DEF_PULSE1  = 32'd10,
    parameter logic [31:0] DEF_PULSE2  = 32'd20
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        period_start,
    input  logic        run,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic [31:0] delay,
    output logic [31:0] period,
    output logic [31:0] pulse1,
    output logic [31:0] pulse2,
    output logic [31:0] nut_w,
    output logic [31:0] nut_d,
    output logic [7:0]  cpmg,
    output logic [7:0]  att,
    output logic        pulse1_en,
    output logic        pending,
    output logic        frame_err
);

    localparam int unsigned   TW         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_ACK} state_t;

    state_t        state_q, state_d;
    logic [7:0]    code_q;
    logic [31:0]   data_q;
    logic [1:0]    cnt_q;
    logic [TW-1:0] timer_q;
    logic [7:0]    ack_q;

    logic [31:0] s_delay, s_period, s_pulse1, s_pulse2, s_nut_w, s_nut_d;
    logic [7:0]  s_cpmg, s_att;
    logic        s_pulse1_en;

    logic timeout_hit, code_known, wr_en, timeout_evt, overrun, commit;

    assign timeout_hit = (timer_q == TIMER_LAST);
    assign code_known  = (code_q <= 8'd8);
    assign commit      = pending && (!run || period_start);
    assign tx_data     = ack_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (rx_valid) state_d = S_COLLECT;
            S_COLLECT: begin
                if (rx_valid) begin
                    if (cnt_q == 2'd3) state_d = S_WRITE;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE:   state_d = S_ACK;
            S_ACK:     if (!tx_busy) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_start    = (state_q == S_ACK) && !tx_busy;
        wr_en       = (state_q == S_WRITE);
        timeout_evt = (state_q == S_COLLECT) && !rx_valid && timeout_hit;
        overrun     = rx_valid && ((state_q == S_WRITE) || (state_q == S_ACK));
    end

    // Data bytes arrive LSB first; shifting in from the top leaves byte 1 in data_q[7:0].
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            code_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (rx_valid) begin
                code_q  <= rx_data;
                cnt_q   <= '0;
                timer_q <= '0;
            end
        end else if (state_q == S_COLLECT) begin
            if (rx_valid) begin
                data_q  <= {rx_data, data_q[31:8]};
                cnt_q   <= cnt_q + 2'd1;
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ack_q     <= '0;
            frame_err <= 1'b0;
        end else begin
            if (timeout_evt || overrun || (wr_en && !code_known)) frame_err <= 1'b1;
            if (wr_en) ack_q <= code_known ? code_q : 8'hEE;
        end
    end

    // A write in the same cycle as a commit wins on pending, so the new value waits one period.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_delay     <= DEF_DELAY;
            s_period    <= DEF_PERIOD;
            s_pulse1    <= DEF_PULSE1;
            s_pulse2    <= DEF_PULSE2;
            s_nut_w     <= '0;
            s_nut_d     <= '0;
            s_cpmg      <= '0;
            s_att       <= '0;
            s_pulse1_en <= 1'b1;
            pending     <= 1'b0;
        end else begin
            if (commit) pending <= 1'b0;
            if (wr_en && code_known) begin
                pending <= 1'b1;
                case (code_q)
                    8'd0:    s_delay     <= data_q;
                    8'd1:    s_period    <= data_q;
                    8'd2:    s_pulse1    <= data_q;
                    8'd3:    s_pulse2    <= data_q;
                    8'd4:    s_pulse1_en <= data_q[0];
                    8'd5:    s_cpmg      <= data_q[7:0];
                    8'd6:    s_att       <= data_q[7:0];
                    8'd7:    s_nut_w     <= data_q;
                    default: s_nut_d     <= data_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            delay     <= DEF_DELAY;
            period    <= DEF_PERIOD;
            pulse1    <= DEF_PULSE1;
            pulse2    <= DEF_PULSE2;
            nut_w     <= '0;
            nut_d     <= '0;
            cpmg      <= '0;
            att       <= '0;
            pulse1_en <= 1'b1;
        end else if (commit) begin
            delay     <= s_delay;
            period    <= s_period;
            pulse1    <= s_pulse1;
            pulse2    <= s_pulse2;
            nut_w     <= s_nut_w;
            nut_d     <= s_nut_d;
            cpmg      <= s_cpmg;
            att       <= s_att;
            pulse1_en <= s_pulse1_en;
        end
    end

endmodule

// File: tb/tb_pulse_cmd_sched.sv
// Bench for pulse_cmd_sched: directed frames checked every cycle against a register-array
// model of the command protocol, plus hand-computed literal expectations.
module tb_pulse_cmd_sched;

    localparam int unsigned TO     = 300;
    localparam int unsigned PS_PER = 1000;

    logic        clk = 1'b0;
    logic        resetn, rx_valid, period_start, run, tx_busy;
    logic [7:0]  rx_data;
    logic [7:0]  tx_data, cpmg, att;
    logic        tx_start, pulse1_en, pending, frame_err;
    logic [31:0] delay, period, pulse1, pulse2, nut_w, nut_d;

    pulse_cmd_sched #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
        .period_start(period_start), .run(run), .tx_busy(tx_busy),
        .tx_data(tx_data), .tx_start(tx_start),
        .delay(delay), .period(period), .pulse1(pulse1), .pulse2(pulse2),
        .nut_w(nut_w), .nut_d(nut_d), .cpmg(cpmg), .att(att),
        .pulse1_en(pulse1_en), .pending(pending), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int tx_count = 0;
    int ps_cnt = 0;
    int tx_ref;
    bit ps_auto = 0;

    // Model: registers indexed by command code; live is a snapshot of staged.
    logic [31:0] m_stg [9];
    logic [31:0] m_live [9];
    logic [7:0]  m_frame [$];
    logic [7:0]  m_ack;
    bit          m_pend, m_err, m_ackw;
    int          m_sil;

    task automatic model_reset();
        m_stg[0] = 32'd100;  m_stg[1] = 32'd50000; m_stg[2] = 32'd10;
        m_stg[3] = 32'd20;   m_stg[4] = 32'd1;
        for (int i = 5; i < 9; i++) m_stg[i] = 32'd0;
        m_live = m_stg;
        m_frame.delete();
        m_ack = 8'h00; m_pend = 0; m_err = 0; m_ackw = 0; m_sil = 0;
    endtask

    task automatic model_step();
        logic [7:0]  code;
        logic [31:0] val;
        bit          do_commit;
        do_commit = m_pend && (!run || period_start);
        if (do_commit) begin
            m_live = m_stg;
            m_pend = 0;
        end
        if (m_frame.size() == 5) begin
            code = m_frame[0];
            val  = {m_frame[4], m_frame[3], m_frame[2], m_frame[1]};
            m_frame.delete();
            if (code <= 8'd8) begin
                m_stg[code] = val;
                m_pend = 1;
                m_ack = code;
            end else begin
                m_err = 1;
                m_ack = 8'hEE;
            end
            m_ackw = 1;
            if (rx_valid) m_err = 1;
        end else if (m_ackw) begin
            if (rx_valid) m_err = 1;
            if (!tx_busy) m_ackw = 0;
        end else if (rx_valid) begin
            m_frame.push_back(rx_data);
            m_sil = 0;
        end else if (m_frame.size() > 0) begin
            m_sil++;
            if (m_sil == int'(TO)) begin
                m_frame.delete();
                m_err = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("delay", delay, m_live[0]);
        chk("period", period, m_live[1]);
        chk("pulse1", pulse1, m_live[2]);
        chk("pulse2", pulse2, m_live[3]);
        chk("pulse1_en", 32'(pulse1_en), 32'(m_live[4][0]));
        chk("cpmg", 32'(cpmg), 32'(m_live[5][7:0]));
        chk("att", 32'(att), 32'(m_live[6][7:0]));
        chk("nut_w", nut_w, m_live[7]);
        chk("nut_d", nut_d, m_live[8]);
        chk("pending", 32'(pending), 32'(m_pend));
        chk("frame_err", 32'(frame_err), 32'(m_err));
        chk("tx_data", 32'(tx_data), 32'(m_ack));
        chk("tx_start", 32'(tx_start), 32'(m_ackw && !tx_busy));
    endtask

    // Compare on the falling edge, advance the model on the rising edge, return just after it.
    task automatic step();
        @(negedge clk);
        compare_all();
        if (tx_start) tx_count++;
        @(posedge clk);
        if (resetn) model_step();
        #1;
        if (ps_auto) begin
            ps_cnt++;
            period_start = ((ps_cnt % PS_PER) == 0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [31:0] d);
        send_byte(c);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    endtask

    initial begin
        resetn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        period_start = 1'b0; run = 1'b0; tx_busy = 1'b0;
        model_reset();
        repeat (3) step();
        chk("rst_delay", delay, 32'd100);
        chk("rst_period", period, 32'd50000);
        chk("rst_pulse1_en", 32'(pulse1_en), 32'd1);
        resetn = 1'b1;
        step();

        // run = 0: commit follows the write by one cycle
        send_frame(8'h00, 32'd100);
        step();
        chk("t1_tx_start", 32'(tx_start), 32'd1);
        chk("t1_tx_data", 32'(tx_data), 32'h00);
        chk("t1_pend_mid", 32'(pending), 32'd1);
        step();
        chk("t1_delay", delay, 32'd100);
        chk("t1_pend_clr", 32'(pending), 32'd0);

        send_frame(8'h05, 32'h0000_010C); repeat (3) step();
        send_frame(8'h06, 32'hFFFF_FF1F); repeat (3) step();
        send_frame(8'h07, 32'hDEAD_BEEF); repeat (3) step();
        send_frame(8'h08, 32'h0123_4567); repeat (3) step();
        chk("cpmg_lit", 32'(cpmg), 32'h0C);
        chk("att_lit", 32'(att), 32'h1F);
        chk("nutw_lit", nut_w, 32'hDEAD_BEEF);
        chk("nutd_lit", nut_d, 32'h0123_4567);

        // run = 1: commit waits for the period boundary
        run = 1'b1; ps_auto = 1; ps_cnt = 0;
        send_frame(8'h01, 32'd10000);
        repeat (10) step();
        chk("t2_period_hold", period, 32'd50000);
        chk("t2_pending", 32'(pending), 32'd1);
        chk("t2_ack", 32'(tx_data), 32'h01);
        repeat (1000) step();
        chk("t2_period_new", period, 32'd10000);
        chk("t2_pend_clr", 32'(pending), 32'd0);
        ps_auto = 0; period_start = 1'b0;

        // write coincides with period_start: older pending value commits, new one waits
        send_frame(8'h03, 32'd7); repeat (3) step();
        send_frame(8'h02, 32'd300);
        period_start = 1'b1; step(); period_start = 1'b0;
        repeat (2) step();
        chk("t3_pulse2", pulse2, 32'd7);
        chk("t3_pulse1_hold", pulse1, 32'd10);
        chk("t3_pending", 32'(pending), 32'd1);
        period_start = 1'b1; step(); period_start = 1'b0;
        step();
        chk("t3_pulse1_new", pulse1, 32'd300);
        chk("t3_pend_clr", 32'(pending), 32'd0);

        // gap of one cycle less than the timeout keeps the frame alive
        run = 1'b0;
        send_byte(8'h03);
        repeat (TO - 1) step();
        send_byte(8'h09); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        repeat (4) step();
        chk("gap_pulse2", pulse2, 32'd9);
        chk("gap_no_err", 32'(frame_err), 32'd0);

        // timeout discards a partial frame
        tx_ref = tx_count;
        send_byte(8'h02); send_byte(8'h05);
        repeat (TO + 1) step();
        chk("t4_err", 32'(frame_err), 32'd1);
        chk("t4_pulse1", pulse1, 32'd300);
        chk("t4_no_ack", 32'(tx_count - tx_ref), 32'd0);
        send_frame(8'h02, 32'd5); repeat (4) step();
        chk("t4_pulse1_new", pulse1, 32'd5);

        // unknown code
        send_frame(8'h2A, 32'h4433_2211);
        step();
        chk("t5_tx_data", 32'(tx_data), 32'hEE);
        chk("t5_tx_start", 32'(tx_start), 32'd1);
        repeat (3) step();
        chk("t5_pending", 32'(pending), 32'd0);
        chk("t5_nutd", nut_d, 32'h0123_4567);

        // acknowledge deferred by a busy transmitter
        tx_busy = 1'b1;
        tx_ref = tx_count;
        send_frame(8'h04, 32'd0);
        repeat (500) step();
        chk("t6_no_ack", 32'(tx_count - tx_ref), 32'd0);
        chk("t6_p1en", 32'(pulse1_en), 32'd0);
        tx_busy = 1'b0;
        repeat (10) step();
        chk("t6_one_ack", 32'(tx_count - tx_ref), 32'd1);
        chk("t6_ack_code", 32'(tx_data), 32'h04);

        // asynchronous reset mid-frame
        send_byte(8'h01); send_byte(8'hAA);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("t6_rst_period", period, 32'd50000);
        chk("t6_rst_err", 32'(frame_err), 32'd0);
        chk("t6_rst_p1en", 32'(pulse1_en), 32'd1);
        chk("t6_rst_txdata", 32'(tx_data), 32'h00);
        repeat (2) step();
        resetn = 1'b1;
        send_frame(8'h08, 32'h55); repeat (3) step();
        chk("t6_after_rst", nut_d, 32'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
